// File: rtl/mips_bus_pkg.sv
// Shared bus types and constants for the MIPS Avalon-MM system fabric.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OWN0 = 3'd1,
    OWN1 = 3'd2,
    ERR0 = 3'd3,
    ERR1 = 3'd4
  } arb_state_t;

  localparam logic [31:0] BUS_BASE_ADDR   = 32'hBFC00000;
  localparam logic [31:0] BUS_WINDOW_SIZE = 32'h00010000;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } avalon_req_t;

  localparam avalon_req_t AVALON_REQ_IDLE = '{
    address:    32'h0,
    read:       1'b0,
    write:      1'b0,
    writedata:  32'h0,
    byteenable: 4'h0
  };

  function automatic logic req_active(input avalon_req_t r);
    return r.read | r.write;
  endfunction

endpackage

// File: rtl/avalon_addr_window.sv
// Combinational address-window decode: in-window flag and base-relative offset.
module avalon_addr_window
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BUS_BASE_ADDR,
  parameter logic [31:0] WINDOW_SIZE = BUS_WINDOW_SIZE
) (
  input  logic [31:0] i_addr,
  output logic        o_in_window,
  output logic [31:0] o_offset
);

  // Upper bound kept in 33 bits so a window touching 2^32 cannot wrap.
  logic [32:0] w_last;

  assign w_last      = {1'b0, BASE_ADDR} + {1'b0, WINDOW_SIZE} - 33'd1;
  assign o_in_window = (i_addr >= BASE_ADDR) && ({1'b0, i_addr} <= w_last);
  assign o_offset    = i_addr - BASE_ADDR;

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Two-master round-robin Avalon-MM arbiter with window translation and local
// termination of out-of-window or abandoned accesses; one transfer in flight.
module mips_avalon_arbiter
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BUS_BASE_ADDR,
  parameter logic [31:0] WINDOW_SIZE = BUS_WINDOW_SIZE
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_m0_address,
  input  logic        i_m0_read,
  input  logic        i_m0_write,
  input  logic [31:0] i_m0_writedata,
  input  logic [3:0]  i_m0_byteenable,
  output logic        o_m0_waitrequest,
  output logic [31:0] o_m0_readdata,
  input  logic [31:0] i_m1_address,
  input  logic        i_m1_read,
  input  logic        i_m1_write,
  input  logic [31:0] i_m1_writedata,
  input  logic [3:0]  i_m1_byteenable,
  output logic        o_m1_waitrequest,
  output logic [31:0] o_m1_readdata,
  output logic [31:0] o_s_address,
  output logic        o_s_read,
  output logic        o_s_write,
  output logic [31:0] o_s_writedata,
  output logic [3:0]  o_s_byteenable,
  input  logic        i_s_waitrequest,
  input  logic [31:0] i_s_readdata,
  output logic [1:0]  o_grant,
  output logic        o_err
);

  arb_state_t  r_state;
  arb_state_t  w_state_next;
  logic        r_last_grant;       // 1'b0 = m0 served last, 1'b1 = m1
  logic        w_last_grant_next;
  avalon_req_t w_m0_req;
  avalon_req_t w_m1_req;
  avalon_req_t w_s_req;
  logic        w_m0_act;
  logic        w_m1_act;
  logic        w_m0_in_win;
  logic        w_m1_in_win;
  logic [31:0] w_m0_offset;
  logic [31:0] w_m1_offset;

  assign w_m0_req = '{address: i_m0_address, read: i_m0_read, write: i_m0_write,
                      writedata: i_m0_writedata, byteenable: i_m0_byteenable};
  assign w_m1_req = '{address: i_m1_address, read: i_m1_read, write: i_m1_write,
                      writedata: i_m1_writedata, byteenable: i_m1_byteenable};
  assign w_m0_act = req_active(w_m0_req);
  assign w_m1_act = req_active(w_m1_req);

  avalon_addr_window #(.BASE_ADDR(BASE_ADDR), .WINDOW_SIZE(WINDOW_SIZE)) u_win_m0 (
    .i_addr      (i_m0_address),
    .o_in_window (w_m0_in_win),
    .o_offset    (w_m0_offset)
  );

  avalon_addr_window #(.BASE_ADDR(BASE_ADDR), .WINDOW_SIZE(WINDOW_SIZE)) u_win_m1 (
    .i_addr      (i_m1_address),
    .o_in_window (w_m1_in_win),
    .o_offset    (w_m1_offset)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    case (r_state)
      IDLE: begin
        // m0 wins unless m1 also requests and m0 was the last one served
        if (w_m0_act && (!w_m1_act || r_last_grant)) begin
          w_state_next = w_m0_in_win ? OWN0 : ERR0;
        end else if (w_m1_act) begin
          w_state_next = w_m1_in_win ? OWN1 : ERR1;
        end else begin
          w_state_next = IDLE;
        end
      end
      OWN0: begin
        if (!w_m0_act) begin
          w_state_next = IDLE;
        end else if (!i_s_waitrequest) begin
          w_state_next      = IDLE;
          w_last_grant_next = 1'b0;
        end else begin
          w_state_next = OWN0;
        end
      end
      OWN1: begin
        if (!w_m1_act) begin
          w_state_next = IDLE;
        end else if (!i_s_waitrequest) begin
          w_state_next      = IDLE;
          w_last_grant_next = 1'b1;
        end else begin
          w_state_next = OWN1;
        end
      end
      ERR0: begin
        w_state_next      = IDLE;
        w_last_grant_next = 1'b0;
      end
      ERR1: begin
        w_state_next      = IDLE;
        w_last_grant_next = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_s_req          = AVALON_REQ_IDLE;
    o_grant          = 2'b00;
    o_err            = 1'b0;
    o_m0_waitrequest = 1'b1;
    o_m0_readdata    = 32'h0;
    o_m1_waitrequest = 1'b1;
    o_m1_readdata    = 32'h0;
    case (r_state)
      IDLE: begin
        o_grant = 2'b00;
      end
      OWN0: begin
        o_grant          = 2'b01;
        w_s_req          = w_m0_req;
        w_s_req.address  = w_m0_offset;
        o_m0_waitrequest = i_s_waitrequest;
        o_m0_readdata    = i_s_readdata;
        if (!w_m0_act) begin
          w_s_req.read  = 1'b0;
          w_s_req.write = 1'b0;
          o_err         = 1'b1;
        end else begin
          o_err = 1'b0;
        end
      end
      OWN1: begin
        o_grant          = 2'b10;
        w_s_req          = w_m1_req;
        w_s_req.address  = w_m1_offset;
        o_m1_waitrequest = i_s_waitrequest;
        o_m1_readdata    = i_s_readdata;
        if (!w_m1_act) begin
          w_s_req.read  = 1'b0;
          w_s_req.write = 1'b0;
          o_err         = 1'b1;
        end else begin
          o_err = 1'b0;
        end
      end
      ERR0: begin
        o_grant          = 2'b01;
        o_m0_waitrequest = 1'b0;
        o_err            = 1'b1;
      end
      ERR1: begin
        o_grant          = 2'b10;
        o_m1_waitrequest = 1'b0;
        o_err            = 1'b1;
      end
      default: begin
        o_grant = 2'b00;
      end
    endcase
  end

  assign o_s_address    = w_s_req.address;
  assign o_s_read       = w_s_req.read;
  assign o_s_write      = w_s_req.write;
  assign o_s_writedata  = w_s_req.writedata;
  assign o_s_byteenable = w_s_req.byteenable;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Scoreboard bench for mips_avalon_arbiter: directed master transfers against a
// small RAM model with programmable wait states.
`timescale 1ns/1ps
module tb_mips_avalon_arbiter;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      m_read, m_write;
  logic [1:0][31:0] m_addr, m_wdata;
  logic [1:0][3:0] m_be;
  logic            m0_wait, m1_wait;
  logic [31:0]     m0_rdata, m1_rdata;
  logic [1:0]      m_wait;
  logic [31:0]     s_address, s_wdata, s_rdata;
  logic            s_read, s_write, s_wait;
  logic [3:0]      s_be;
  logic [1:0]      grant;
  logic            err;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        is_rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   q_viol = 0;
  int   done_log[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic saw_sread = 1'b0;

  // RAM model
  logic [31:0] mem [0:1023];
  logic        written [0:1023];
  int          wait_cfg = 0;
  int          s_cnt = 0;
  logic [9:0]  s_idx;

  function automatic logic [31:0] pat(input logic [9:0] w);
    return {16'hA5A5, 6'd0, w};
  endfunction

  assign m_wait  = {m1_wait, m0_wait};
  assign s_idx   = s_address[11:2];
  assign s_wait  = (s_read | s_write) && (s_cnt < wait_cfg);
  assign s_rdata = written[s_idx] ? mem[s_idx] : pat(s_idx);

  always @(posedge clk) begin
    if (reset) begin
      s_cnt <= 0;
      for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
    end else if (!(s_read | s_write)) begin
      s_cnt <= 0;
    end else if (s_wait) begin
      s_cnt <= s_cnt + 1;
    end else begin
      s_cnt <= 0;
      if (s_write) begin
        mem[s_idx]     <= {s_be[3] ? s_wdata[31:24] : s_rdata[31:24],
                           s_be[2] ? s_wdata[23:16] : s_rdata[23:16],
                           s_be[1] ? s_wdata[15:8]  : s_rdata[15:8],
                           s_be[0] ? s_wdata[7:0]   : s_rdata[7:0]};
        written[s_idx] <= 1'b1;
      end
    end
  end

  mips_avalon_arbiter dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_m0_address     (m_addr[0]),
    .i_m0_read        (m_read[0]),
    .i_m0_write       (m_write[0]),
    .i_m0_writedata   (m_wdata[0]),
    .i_m0_byteenable  (m_be[0]),
    .o_m0_waitrequest (m0_wait),
    .o_m0_readdata    (m0_rdata),
    .i_m1_address     (m_addr[1]),
    .i_m1_read        (m_read[1]),
    .i_m1_write       (m_write[1]),
    .i_m1_writedata   (m_wdata[1]),
    .i_m1_byteenable  (m_be[1]),
    .o_m1_waitrequest (m1_wait),
    .o_m1_readdata    (m1_rdata),
    .o_s_address      (s_address),
    .o_s_read         (s_read),
    .o_s_write        (s_write),
    .o_s_writedata    (s_wdata),
    .o_s_byteenable   (s_be),
    .i_s_waitrequest  (s_wait),
    .i_s_readdata     (s_rdata),
    .o_grant          (grant),
    .o_err            (err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completion and on every bare err pulse
  always @(negedge clk) begin
    exp_t e;
    logic any_done;
    any_done = 1'b0;
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        if ((m_read[m] | m_write[m]) && !m_wait[m]) begin
          any_done = 1'b1;
          done_log.push_back(m);
          if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_completion_m%0d", m), 32'd1, 32'd0);
          end else begin
            if (m == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("err_at_completion_m%0d", m), {31'd0, err}, {31'd0, e.err});
            if (e.is_rd)
              check($sformatf("readdata_m%0d", m), (m == 0) ? m0_rdata : m1_rdata, e.rd);
          end
        end
      end
      if (err && !any_done) begin
        if (q_viol == 0) begin
          check("unexpected_err_pulse", 32'd1, 32'd0);
        end else begin
          q_viol--;
          check("violation_err", {31'd0, err}, 32'd1);
        end
      end
      if (grant == 2'b01) begin
        check("m1_wait_during_m0", {31'd0, m1_wait}, 32'd1);
        check("m1_rdata_during_m0", m1_rdata, 32'h0);
      end
      if (s_read) saw_sread = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
    m_addr[m]  = addr;
    m_wdata[m] = data;
    m_be[m]    = be;
    m_read[m]  = !wr;
    m_write[m] = wr;
  endtask

  task automatic expect_xfer(input int m, input logic [31:0] rd, input logic e_err, input logic is_rd);
    exp_t e;
    e.rd    = rd;
    e.err   = e_err;
    e.is_rd = is_rd;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_done(input int m);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if ((m_read[m] | m_write[m]) && !m_wait[m]) done = 1'b1;
    end
    check($sformatf("completion_timeout_m%0d", m), {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    m_read[m]  = 1'b0;
    m_write[m] = 1'b0;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    m_read  = 2'b00;
    m_write = 2'b00;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_s_read", {31'd0, s_read}, 32'd0);
    check("rst_s_write", {31'd0, s_write}, 32'd0);
    check("rst_s_address", s_address, 32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_s_be", {28'd0, s_be}, 32'd0);
    check("rst_m0_wait", {31'd0, m0_wait}, 32'd1);
    check("rst_m1_wait", {31'd0, m1_wait}, 32'd1);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    check("rst_err", {31'd0, err}, 32'd0);

    // m0 read at window base, two slave wait states
    wait_cfg = 2;
    step();
    set_req(0, 1'b0, 32'hBFC00000, 32'h0, 4'hF);
    expect_xfer(0, 32'hA5A50000, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_idle_grant", {30'd0, grant}, 32'd0);
    check("t1_idle_m0_wait", {31'd0, m0_wait}, 32'd1);
    @(negedge clk);
    check("t1_grant", {30'd0, grant}, 32'd1);
    check("t1_s_address", s_address, 32'h0);
    check("t1_s_read", {31'd0, s_read}, 32'd1);
    check("t1_m0_stall", {31'd0, m0_wait}, 32'd1);
    wait_done(0);
    @(negedge clk);
    check("t1_back_idle", {30'd0, grant}, 32'd0);

    // simultaneous requests from reset, then alternation
    do_reset();
    wait_cfg = 1;
    done_log.delete();
    step();
    set_req(0, 1'b0, 32'hBFC00004, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'hBFC00008, 32'h0, 4'hF);
    expect_xfer(0, 32'hA5A50001, 1'b0, 1'b1);
    expect_xfer(1, 32'hA5A50002, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t2_first_grant", {30'd0, grant}, 32'd1);
    check("t2_m1_wait", {31'd0, m1_wait}, 32'd1);
    fork
      wait_done(0);
      wait_done(1);
    join
    check("t2_order_count", done_log.size(), 32'd2);
    if (done_log.size() == 2) begin
      check("t2_order_first", done_log[0], 32'd0);
      check("t2_order_second", done_log[1], 32'd1);
    end
    done_log.delete();
    step();
    set_req(0, 1'b0, 32'hBFC0000C, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'hBFC00010, 32'h0, 4'hF);
    expect_xfer(0, 32'hA5A50003, 1'b0, 1'b1);
    expect_xfer(1, 32'hA5A50004, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t2_third_grant", {30'd0, grant}, 32'd1);
    fork
      wait_done(0);
      wait_done(1);
    join
    if (done_log.size() == 2) check("t2_third_first", done_log[0], 32'd0);
    else check("t2_third_count", done_log.size(), 32'd2);

    // m1 write then m0 read-back
    step();
    set_req(1, 1'b1, 32'hBFC00404, 32'hCAFEF00D, 4'b1111);
    expect_xfer(1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t3_grant", {30'd0, grant}, 32'd2);
    check("t3_s_write", {31'd0, s_write}, 32'd1);
    check("t3_s_address", s_address, 32'h404);
    check("t3_s_wdata", s_wdata, 32'hCAFEF00D);
    check("t3_s_be", {28'd0, s_be}, 32'hF);
    check("t3_m0_wait", {31'd0, m0_wait}, 32'd1);
    wait_done(1);
    check("t3_ram_word", mem[10'h101], 32'hCAFEF00D);
    step();
    set_req(0, 1'b0, 32'hBFC00404, 32'h0, 4'hF);
    expect_xfer(0, 32'hCAFEF00D, 1'b0, 1'b1);
    wait_done(0);

    // out-of-window reads terminate locally
    saw_sread = 1'b0;
    step();
    set_req(0, 1'b0, 32'h00000000, 32'h0, 4'hF);
    expect_xfer(0, 32'h0, 1'b1, 1'b1);
    wait_done(0);
    @(negedge clk);
    check("t4_err_one_cycle", {31'd0, err}, 32'd0);
    check("t4_wait_back_high", {31'd0, m0_wait}, 32'd1);
    step();
    set_req(0, 1'b0, 32'hBFC10000, 32'h0, 4'hF);
    expect_xfer(0, 32'h0, 1'b1, 1'b1);
    wait_done(0);
    @(negedge clk);
    check("t4_no_s_read", {31'd0, saw_sread}, 32'd0);

    // m0 abandons a stalled read while m1 waits
    wait_cfg = 3;
    step();
    set_req(0, 1'b0, 32'hBFC00000, 32'h0, 4'hF);
    q_viol++;
    @(negedge clk);
    step();
    set_req(1, 1'b0, 32'hBFC00008, 32'h0, 4'hF);
    expect_xfer(1, 32'hA5A50002, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_grant_m0", {30'd0, grant}, 32'd1);
    step();
    m_read[0] = 1'b0;
    @(negedge clk);
    check("t5_err", {31'd0, err}, 32'd1);
    check("t5_s_read_low", {31'd0, s_read}, 32'd0);
    @(negedge clk);
    check("t5_bubble", {30'd0, grant}, 32'd0);
    @(negedge clk);
    check("t5_grant_m1", {30'd0, grant}, 32'd2);
    wait_done(1);

    // reset while m1 is stalled
    wait_cfg = 5;
    step();
    set_req(1, 1'b0, 32'hBFC00008, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("t6_grant_m1", {30'd0, grant}, 32'd2);
    check("t6_stalled", {31'd0, m1_wait}, 32'd1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("t6_grant", {30'd0, grant}, 32'd0);
    check("t6_s_read", {31'd0, s_read}, 32'd0);
    check("t6_s_write", {31'd0, s_write}, 32'd0);
    check("t6_s_address", s_address, 32'h0);
    check("t6_m0_wait", {31'd0, m0_wait}, 32'd1);
    check("t6_m1_wait", {31'd0, m1_wait}, 32'd1);
    m_read[1] = 1'b0;
    step();
    reset = 1'b0;
    repeat (3) step();

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("viol_drained", q_viol, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
